// File: rtl/oled_stim_seq.sv
// OLED stimulation sequencer.
// Runs STIM/REST LED frames for one pattern, then sweeps every pixel
// address through SETTLE/LOAD so the IC latches the dis_led mask bit.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | sequencer parked, counters and pixel address cleared
// WAIT_PAT | waiting for a pattern from the FIFO and a locked LED PLL
// STIM     | LED emission on, counting stim_pulses pulse ticks
// REST     | LED emission off, counting rest_pulses, then next frame
// SETTLE   | pixel address held while the mask read settles
// LOAD     | one-cycle load strobe to the IC
// NEXT_PIX | advance the pixel address or finish the sweep
module oled_stim_seq #(
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 32,
  parameter int SETTLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pll_locked,
  input  logic                pulse_tick,
  input  logic                pattern_valid,
  input  logic                mode,
  input  logic [CNT_W-1:0]    stim_pulses,
  input  logic [CNT_W-1:0]    rest_pulses,
  input  logic [CNT_W-1:0]    stim_frames,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                mask_rdata,
  output logic                led_on_clk_en,
  output logic                load,
  output logic                next_pattern,
  output logic [ADDR_W-1:0]   pix_addr,
  output logic                dis_led,
  output logic                busy,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PAT = 3'd1,
    S_STIM     = 3'd2,
    S_REST     = 3'd3,
    S_SETTLE   = 3'd4,
    S_LOAD     = 3'd5,
    S_NEXT_PIX = 3'd6
  } state_t;

  // Two settle clocks are the floor: one for the RAM read, one for dis_led.
  localparam logic [SETTLE_W-1:0] SETTLE_MIN = SETTLE_W'(2);

  state_t              r_state;
  logic [CNT_W-1:0]    r_pulse_cnt;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [ADDR_W-1:0]   r_pix_addr;
  logic                r_led_on;
  logic                r_load;
  logic                r_next_pattern;
  logic                r_dis_led;

  logic [CNT_W-1:0]    w_frames_tgt;
  logic [SETTLE_W-1:0] w_settle_tgt;
  logic                w_stim_done;
  logic                w_rest_done;
  logic                w_frame_last;
  logic                w_settle_done;
  logic                w_pix_last;

  // A zero pulse count ends the phase without waiting for a tick; the >=
  // compare keeps counters from running past a target lowered mid-frame.
  assign w_frames_tgt  = (stim_frames == '0) ? CNT_W'(1) : stim_frames;
  assign w_settle_tgt  = (settle_cycles < SETTLE_MIN) ? SETTLE_MIN : settle_cycles;
  assign w_stim_done   = (stim_pulses == '0) ||
                         (pulse_tick && (r_pulse_cnt >= stim_pulses - 1'b1));
  assign w_rest_done   = (rest_pulses == '0) ||
                         (pulse_tick && (r_pulse_cnt >= rest_pulses - 1'b1));
  assign w_frame_last  = (r_frame_cnt >= w_frames_tgt - 1'b1);
  assign w_settle_done = (r_settle_cnt >= w_settle_tgt - 1'b1);
  assign w_pix_last    = &r_pix_addr;

  // Sequencer state, counters and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pulse_cnt    <= '0;
      r_frame_cnt    <= '0;
      r_settle_cnt   <= '0;
      r_pix_addr     <= '0;
      r_led_on       <= 1'b0;
      r_load         <= 1'b0;
      r_next_pattern <= 1'b0;
    end else begin
      r_load         <= 1'b0;
      r_next_pattern <= 1'b0;
      r_led_on       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pulse_cnt  <= '0;
          r_frame_cnt  <= '0;
          r_settle_cnt <= '0;
          r_pix_addr   <= '0;
          if (en) r_state <= S_WAIT_PAT;
        end
        S_WAIT_PAT: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (pattern_valid && pll_locked) begin
            r_state     <= S_STIM;
            r_led_on    <= 1'b1;
            r_pulse_cnt <= '0;
          end
        end
        S_STIM: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (!pll_locked) begin
            r_led_on <= 1'b1;
          end else if (w_stim_done) begin
            r_state     <= S_REST;
            r_pulse_cnt <= '0;
          end else begin
            r_led_on <= 1'b1;
            if (pulse_tick) r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end
        S_REST: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (pll_locked && w_rest_done) begin
            r_pulse_cnt <= '0;
            if (w_frame_last) begin
              // Pattern finished: frame count is consumed, sweep starts at pixel 0.
              r_state      <= S_SETTLE;
              r_frame_cnt  <= '0;
              r_pix_addr   <= '0;
              r_settle_cnt <= '0;
            end else begin
              r_state     <= S_STIM;
              r_frame_cnt <= r_frame_cnt + 1'b1;
              r_led_on    <= 1'b1;
            end
          end else if (pll_locked && pulse_tick) begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_state <= S_LOAD;
            r_load  <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_NEXT_PIX;
        end
        S_NEXT_PIX: begin
          r_settle_cnt <= '0;
          if (w_pix_last) begin
            r_pix_addr     <= '0;
            r_next_pattern <= 1'b1;
            r_state        <= (mode && en) ? S_WAIT_PAT : S_IDLE;
          end else begin
            r_pix_addr <= r_pix_addr + 1'b1;
            r_state    <= S_SETTLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_pulse_cnt  <= '0;
          r_frame_cnt  <= '0;
          r_settle_cnt <= '0;
          r_pix_addr   <= '0;
        end
      endcase
    end
  end

  // Mask RAM has one cycle of read latency; dis_led lags pix_addr by two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dis_led <= 1'b0;
    else        r_dis_led <= mask_rdata;
  end

  assign led_on_clk_en = r_led_on;
  assign load          = r_load;
  assign next_pattern  = r_next_pattern;
  assign pix_addr      = r_pix_addr;
  assign dis_led       = r_dis_led;
  assign busy          = (r_state != S_IDLE);
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_oled_stim_seq.sv
// Directed bench for oled_stim_seq with a 4-pixel array.
module tb_oled_stim_seq;
  localparam int ADDR_W   = 2;
  localparam int CNT_W    = 32;
  localparam int SETTLE_W = 4;
  localparam int NPIX     = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic                pll_locked;
  logic                pulse_tick;
  logic                pattern_valid;
  logic                mode;
  logic [CNT_W-1:0]    stim_pulses;
  logic [CNT_W-1:0]    rest_pulses;
  logic [CNT_W-1:0]    stim_frames;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                mask_rdata;
  logic                led_on_clk_en;
  logic                load;
  logic                next_pattern;
  logic [ADDR_W-1:0]   pix_addr;
  logic                dis_led;
  logic                busy;
  logic [2:0]          state_dbg;

  oled_stim_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pll_locked(pll_locked),
    .pulse_tick(pulse_tick), .pattern_valid(pattern_valid), .mode(mode),
    .stim_pulses(stim_pulses), .rest_pulses(rest_pulses),
    .stim_frames(stim_frames), .settle_cycles(settle_cycles),
    .mask_rdata(mask_rdata), .led_on_clk_en(led_on_clk_en), .load(load),
    .next_pattern(next_pattern), .pix_addr(pix_addr), .dis_led(dis_led),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Mask RAM model: one-cycle read latency.
  logic [NPIX-1:0] mask_bits = 4'b0000;
  always @(posedge clk) mask_rdata <= mask_bits[pix_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit tick_en = 1'b0;
  int stim_ticks, frozen_ticks, rest_ticks, bursts, loads, np_cnt;
  int addr_err, dis_err, settle_err, overlap_err, run_len, exp_settle;
  int np_state;
  logic prev_led;

  typedef struct {
    int       stim_p;
    int       rest_p;
    int       frames;
    int       settle;
    bit       ticks;
    bit [3:0] mask;
    int       exp_bursts;
    int       exp_stim;
    int       exp_rest;
    int       exp_settle;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_acc();
    stim_ticks = 0; frozen_ticks = 0; rest_ticks = 0; bursts = 0;
    loads = 0; np_cnt = 0; addr_err = 0; dis_err = 0; settle_err = 0;
    overlap_err = 0; run_len = 0; np_state = -1;
    prev_led = led_on_clk_en;
  endtask

  // One clock: drive the tick for this cycle, account inputs against the
  // current state, then sample outputs at the following falling edge.
  task automatic step();
    cyc++;
    pulse_tick = tick_en && (cyc % 4 == 0);
    if (pulse_tick && state_dbg == 3'd2) begin
      if (pll_locked) stim_ticks++;
      else            frozen_ticks++;
    end
    if (pulse_tick && state_dbg == 3'd3 && pll_locked) rest_ticks++;
    @(negedge clk);
    if (led_on_clk_en && !prev_led) bursts++;
    prev_led = led_on_clk_en;
    if (state_dbg == 3'd4) run_len++;
    if (load) begin
      if (int'(pix_addr) != loads) addr_err++;
      if (dis_led != mask_bits[loads % NPIX]) dis_err++;
      if (run_len != exp_settle) settle_err++;
      if (next_pattern || led_on_clk_en) overlap_err++;
      run_len = 0;
      loads++;
    end
    if (next_pattern) begin
      np_cnt++;
      np_state = state_dbg;
    end
  endtask

  task automatic run_until_np(input int budget);
    int n;
    n = 0;
    while (np_cnt == 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_for(input int st, input int pix, input int budget, input string name);
    int n;
    n = 0;
    while (!(state_dbg == st && (pix < 0 || int'(pix_addr) == pix)) && n < budget) begin
      step();
      n++;
    end
    check(name, (state_dbg == st && (pix < 0 || int'(pix_addr) == pix)) ? 1 : 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},   led_on_clk_en, 0);
    check({tag, "_load"},  load, 0);
    check({tag, "_np"},    next_pattern, 0);
    check({tag, "_pix"},   pix_addr, 0);
    check({tag, "_dis"},   dis_led, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic set_cfg(input int sp, input int rp, input int fr, input int st);
    stim_pulses   = CNT_W'(sp);
    rest_pulses   = CNT_W'(rp);
    stim_frames   = CNT_W'(fr);
    settle_cycles = SETTLE_W'(st);
  endtask

  initial begin
    // stim, rest, frames, settle, ticks, mask, bursts, stim_ticks, rest_ticks, settle_len
    vecs[0] = '{3, 2, 2, 0, 1'b1, 4'b1010, 2, 6, 4, 2};
    vecs[1] = '{1, 1, 3, 5, 1'b1, 4'b0110, 3, 3, 3, 5};
    vecs[2] = '{0, 0, 0, 1, 1'b0, 4'b0101, 1, 0, 0, 2};
    vecs[3] = '{2, 3, 1, 3, 1'b1, 4'b1001, 1, 2, 3, 3};

    rst_n = 1'b0; en = 1'b0; pll_locked = 1'b0; pulse_tick = 1'b0;
    pattern_valid = 1'b0; mode = 1'b0;
    set_cfg(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    reset_acc();
    step();
    check("idle_after_rst", state_dbg, 0);

    // Table-driven single-shot runs.
    for (int i = 0; i < 4; i++) begin
      set_cfg(vecs[i].stim_p, vecs[i].rest_p, vecs[i].frames, vecs[i].settle);
      mode = 1'b0; pll_locked = 1'b1; pattern_valid = 1'b1;
      tick_en = vecs[i].ticks;
      mask_bits = vecs[i].mask;
      exp_settle = vecs[i].exp_settle;
      reset_acc();
      en = 1'b1;
      run_until_np(600);
      en = 1'b0;
      check($sformatf("r%0d_bursts", i), bursts, vecs[i].exp_bursts);
      check($sformatf("r%0d_stim_ticks", i), stim_ticks, vecs[i].exp_stim);
      check($sformatf("r%0d_rest_ticks", i), rest_ticks, vecs[i].exp_rest);
      check($sformatf("r%0d_loads", i), loads, NPIX);
      check($sformatf("r%0d_np_cnt", i), np_cnt, 1);
      check($sformatf("r%0d_np_state", i), np_state, 0);
      check($sformatf("r%0d_addr_err", i), addr_err, 0);
      check($sformatf("r%0d_dis_err", i), dis_err, 0);
      check($sformatf("r%0d_settle_err", i), settle_err, 0);
      check($sformatf("r%0d_overlap_err", i), overlap_err, 0);
      step();
      step();
      check($sformatf("r%0d_idle_hold", i), state_dbg, 0);
    end

    // PLL drop for 10 clocks mid-STIM: state and count freeze.
    set_cfg(3, 1, 1, 0);
    exp_settle = 2; tick_en = 1'b1; mask_bits = 4'b1100;
    reset_acc();
    en = 1'b1;
    begin
      int n;
      int held_bad;
      n = 0;
      while (stim_ticks < 1 && n < 200) begin
        step();
        n++;
      end
      check("pll_pre_tick", stim_ticks, 1);
      pll_locked = 1'b0;
      held_bad = 0;
      repeat (10) begin
        step();
        if (state_dbg != 3'd2 || !led_on_clk_en) held_bad++;
      end
      pll_locked = 1'b1;
      check("pll_held_stim", held_bad, 0);
    end
    run_until_np(600);
    en = 1'b0;
    check("pll_stim_ticks", stim_ticks, 3);
    check("pll_frozen_ticks", frozen_ticks, 2);
    check("pll_loads", loads, NPIX);
    check("pll_dis_err", dis_err, 0);
    step();

    // Continuous mode: straight back to WAIT_PAT then STIM.
    set_cfg(1, 1, 1, 0);
    exp_settle = 2; mode = 1'b1;
    reset_acc();
    en = 1'b1;
    run_until_np(600);
    check("cont_np_cnt", np_cnt, 1);
    check("cont_np_state", np_state, 1);
    step();
    check("cont_stim", state_dbg, 2);
    check("cont_busy", busy, 1);
    en = 1'b0;
    step();
    check("en_drop_stim", state_dbg, 0);
    mode = 1'b0;
    step();

    // en dropped in REST.
    set_cfg(1, 3, 1, 0);
    reset_acc();
    en = 1'b1;
    wait_for(3, -1, 200, "reach_rest");
    en = 1'b0;
    step();
    check("en_drop_rest_state", state_dbg, 0);
    check("en_drop_rest_led", led_on_clk_en, 0);

    // en dropped in SETTLE: sweep still completes.
    set_cfg(1, 1, 1, 2);
    exp_settle = 2; mask_bits = 4'b0011;
    reset_acc();
    en = 1'b1;
    wait_for(4, -1, 200, "reach_settle");
    en = 1'b0;
    run_until_np(600);
    check("settle_drop_loads", loads, NPIX);
    check("settle_drop_np", np_cnt, 1);
    check("settle_drop_np_state", np_state, 0);
    check("settle_drop_addr_err", addr_err, 0);
    check("settle_drop_settle_err", settle_err, 0);
    step();
    check("settle_drop_idle", state_dbg, 0);

    // Reset pulsed mid-SETTLE at pixel 2.
    set_cfg(1, 1, 1, 5);
    exp_settle = 5;
    reset_acc();
    en = 1'b1;
    wait_for(4, 2, 400, "reach_pix2");
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    en = 1'b0;
    reset_acc();
    rst_n = 1'b1;
    #1;
    check("rst_rel_state", state_dbg, 0);
    repeat (4) step();
    check("rst_rel_loads", loads, 0);
    check("rst_rel_np", np_cnt, 0);
    check("rst_rel_idle", state_dbg, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
